wrapped_project_mux: RTL
========================

# wrapped_project_mux

Multi-slot successor to the single-project Caravel wrapper: hosts NUM_SLOTS user projects behind one Wishbone slave, one logic-analyzer port and one IO pad bank. Decodes host Wishbone into per-slot windows plus a local CSR window, with a bus-timeout guard, and routes IO/LA from a CSR-selected slot. All top-level outputs are gated by `active`: tristate in synthesis, forced to 0 under `FORMAL`.

## Interface
- NUM_SLOTS, 4, hosted projects (1..7)
- IO_PADS, 38, pad count (MPRJ_IO_PADS)
- SLOT_SPAN_LOG2, 12, log2 bytes per address window
- TIMEOUT_CYCLES, 255, max cycles a slot may hold a transfer (≥2)
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset, synchronous, active-low (asserted when 0)
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1  host Wishbone controls
- wbs_sel_i  in  4; wbs_adr_i, wbs_dat_i  in  32  host Wishbone
- wbs_ack_o  out  1; wbs_dat_o  out  32  host response
- la_data_in, la_oenb  in  32; la_data_out  out  32
- io_in  in  IO_PADS; io_out, io_oeb  out  IO_PADS
- irq  out  3
- active  in  1  output gate enable
- slot_cyc_o, slot_stb_o  out  NUM_SLOTS  one-hot per-slot strobes
- slot_we_o  out 1; slot_sel_o  out 4; slot_adr_o, slot_dat_o  out 32  shared, registered
- slot_ack_i  in  NUM_SLOTS; slot_dat_i  in  32*NUM_SLOTS
- slot_io_out_i, slot_io_oeb_i  in  IO_PADS*NUM_SLOTS
- slot_la_data_out_i  in  32*NUM_SLOTS; slot_irq_i  in  3*NUM_SLOTS
- la_data_in and io_in fan out unregistered to all slots (parent wiring).

## Operation
- Region r = wbs_adr_i[SLOT_SPAN_LOG2 +: clog2(NUM_SLOTS+1)]; r=0 CSR, r=1..NUM_SLOTS slot r-1, else unmapped. Upper bits ignored.
- CSRs (adr[3:2]): 0 SEL r/w [2:0]; 1 TOUT_STATUS [NUM_SLOTS-1:0] sticky, write-1-to-clear; 2 IRQ_EN [NUM_SLOTS-1:0] r/w; 3 reads 0, writes ignored. Writes honour wbs_sel_i byte lanes.
- FSM: IDLE → (cyc&stb) → CSR_RESP | SLOT_WAIT | ERR_RESP(unmapped); SLOT_WAIT → RESP on slot ack, → ERR_RESP on timeout, → IDLE on host cyc drop; *_RESP → IDLE.
- On SLOT_WAIT entry: latch we/sel/dat, slot_adr_o = adr[SLOT_SPAN_LOG2-1:0] zero-extended; assert that slot's cyc/stb until ack, timeout or abort.
- Timeout: counter clears on entry; if no ack when counter reaches TIMEOUT_CYCLES-1, drop strobe, set TOUT_STATUS[slot], ack host with 32'hDEAD_BEEF.
- Unmapped: ack with 0, no side effect. Acks from non-addressed slots, or outside SLOT_WAIT, ignored.
- Routing: SEL<NUM_SLOTS → io_out/io_oeb/la_data_out from slot SEL; otherwise io_out=0, io_oeb=all 1, la_data_out=0. Combinational.
- irq = OR over slots with IRQ_EN set of slot_irq_i; irq[2] additionally ORed with |TOUT_STATUS.
- Gating as summary; gate placed after routing.

## Timing
- Reset (wb_rst_i=0 at edge): state IDLE, wbs_ack_o=0, wbs_dat_o=0, slot strobes 0, counter 0, SEL=0, IRQ_EN=0, TOUT_STATUS=0. Reset mid-transfer drops strobes next edge; no ack issued.
- CSR/unmapped: request seen at edge k → ack high cycle k+1, one cycle exactly.
- Slot: request at edge k → slot_stb high from k+1; slot ack in cycle m → host ack cycle m+1, slot_stb low in m+1.
- Ack always a single-cycle pulse; wbs_dat_o valid with ack, held until next ack. Next request accepted cycle after ack (2-cycle min access).
- Slot ack and timeout in same cycle: ack wins, no sticky set.
- Host cyc drop in SLOT_WAIT: strobe drops next edge, no host ack, no sticky.
- SEL change takes effect on pads the cycle after the write ack.

## Structure
- Package wrapped_project_mux_pkg: FSM state enum, CSR offsets, ERR_DATA=32'hDEAD_BEEF, region-index width function.
- Sub-module active_gate (param WIDTH): active ? in : z (0 under FORMAL), instantiated per output bus.

## Test plan
- Reset, SEL/IRQ_EN read → 0; io_oeb=0 from slot 0 (stub oeb=0), ack never high during reset.
- Write SEL=2, read back; slot 2 drives io_out=38'h15 → io_out=38'h15 cycle after ack; SEL=5 → io_out=0, io_oeb all 1.
- Write 0xA5A5_0001 to slot 1 offset 0x10, stub acks after 3 cycles → slot_adr_o=0x10, host ack exactly 4 cycles after stb sample, read returns stub data.
- Silent slot 3 → ack at cycle TIMEOUT_CYCLES+1 with 0xDEAD_BEEF, TOUT_STATUS=0x8, irq[2]=1; write 0x8 to TOUT_STATUS → clears, irq[2]=0.
- Ack coincident with final timeout cycle → real data returned, TOUT_STATUS unchanged; cyc dropped in SLOT_WAIT → no ack, strobe low next edge.
- active=0 → all outputs 0 under FORMAL, internal CSR writes still take effect.

Source files
------------

// File: rtl/wrapped_project_mux_pkg.sv
// Shared definitions for the multi-slot project mux.
// Contents: host-side FSM state encoding, CSR word offsets, the error data
// word returned on a slot timeout, and the region-index width helper.
package wrapped_project_mux_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CSR_RESP  = 3'd1,
      ST_SLOT_WAIT = 3'd2,
      ST_RESP      = 3'd3,
      ST_ERR_RESP  = 3'd4
   } state_t;

   // CSR word offsets, decoded from address bits [3:2]
   localparam logic [1:0] CSR_SEL    = 2'd0;
   localparam logic [1:0] CSR_TOUT   = 2'd1;
   localparam logic [1:0] CSR_IRQ_EN = 2'd2;
   localparam logic [1:0] CSR_RSVD   = 2'd3;

   localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

   // Region 0 is the CSR window, regions 1..num_slots are the slots.
   function automatic int region_width(input int num_slots);
      return $clog2(num_slots + 1);
   endfunction

endpackage

// File: rtl/wrapped_project_mux_if.sv
// Shared Wishbone bus from the mux to the hosted projects.
// master: the mux (drives one-hot cyc/stb and the shared registered
//         we/sel/adr/dat; receives per-slot ack and read data).
// slave : the slot side (the hosted projects or their stand-ins).
interface wrapped_project_mux_if #(
   parameter int NUM_SLOTS = 4
);
   logic [NUM_SLOTS-1:0]    slot_cyc_o;
   logic [NUM_SLOTS-1:0]    slot_stb_o;
   logic                    slot_we_o;
   logic [3:0]              slot_sel_o;
   logic [31:0]             slot_adr_o;
   logic [31:0]             slot_dat_o;
   logic [NUM_SLOTS-1:0]    slot_ack_i;
   logic [32*NUM_SLOTS-1:0] slot_dat_i;

   modport master (
      output slot_cyc_o, slot_stb_o, slot_we_o, slot_sel_o, slot_adr_o, slot_dat_o,
      input  slot_ack_i, slot_dat_i
   );

   modport slave (
      input  slot_cyc_o, slot_stb_o, slot_we_o, slot_sel_o, slot_adr_o, slot_dat_o,
      output slot_ack_i, slot_dat_i
   );
endinterface

// File: rtl/wrapped_project_mux_active_gate.sv
// Output gate for one pad-facing bus.
// Ports: active (enable), in_bus (routed value), out_bus (gated value).
// When inactive the bus floats; formal builds see 0 instead of z.
module active_gate #(
   parameter int WIDTH = 1
) (
   input  logic             active,
   input  logic [WIDTH-1:0] in_bus,
   output wire  [WIDTH-1:0] out_bus
);
`ifdef FORMAL
   assign out_bus = active ? in_bus : {WIDTH{1'b0}};
`else
   assign out_bus = active ? in_bus : {WIDTH{1'bz}};
`endif
endmodule

// File: rtl/wrapped_project_mux.sv
// Multi-slot user-project mux behind one host Wishbone slave.
// Ports:
//   wb_clk_i / wb_rst_i      : clock, synchronous active-low reset
//   wbs_*                    : host Wishbone slave
//   la_*, io_*, irq          : logic analyzer, pads and interrupts, routed
//                              from the CSR-selected slot, gated by active
//   slot_bus                 : shared Wishbone towards the hosted slots
//   slot_io_*, slot_la_*,
//   slot_irq_i               : per-slot pad/LA/irq outputs, packed by slot
// la_data_in and io_in reach the slots directly through parent wiring.
module wrapped_project_mux
   import wrapped_project_mux_pkg::*;
#(
   parameter int NUM_SLOTS      = 4,
   parameter int IO_PADS        = 38,
   parameter int SLOT_SPAN_LOG2 = 12,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                           wb_clk_i,
   input  logic                           wb_rst_i,
   input  logic                           wbs_cyc_i,
   input  logic                           wbs_stb_i,
   input  logic                           wbs_we_i,
   input  logic [3:0]                     wbs_sel_i,
   input  logic [31:0]                    wbs_adr_i,
   input  logic [31:0]                    wbs_dat_i,
   output wire                            wbs_ack_o,
   output wire  [31:0]                    wbs_dat_o,
   input  logic [31:0]                    la_data_in,
   input  logic [31:0]                    la_oenb,
   output wire  [31:0]                    la_data_out,
   input  logic [IO_PADS-1:0]             io_in,
   output wire  [IO_PADS-1:0]             io_out,
   output wire  [IO_PADS-1:0]             io_oeb,
   output wire  [2:0]                     irq,
   input  logic                           active,
   wrapped_project_mux_if.master          slot_bus,
   input  logic [IO_PADS*NUM_SLOTS-1:0]   slot_io_out_i,
   input  logic [IO_PADS*NUM_SLOTS-1:0]   slot_io_oeb_i,
   input  logic [32*NUM_SLOTS-1:0]        slot_la_data_out_i,
   input  logic [3*NUM_SLOTS-1:0]         slot_irq_i
);

   localparam int RW = region_width(NUM_SLOTS);
   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   state_t               state_r, state_s;
   logic [CW-1:0]        cnt_r;
   logic [RW-1:0]        slot_idx_r;
   logic [NUM_SLOTS-1:0] slot_stb_r;
   logic                 we_r;
   logic [3:0]           sel_r;
   logic [31:0]          adr_r;
   logic [31:0]          dat_r;
   logic                 ack_r;
   logic [31:0]          rdat_r;
   logic [2:0]           sel_csr_r;
   logic [NUM_SLOTS-1:0] tout_r;
   logic [NUM_SLOTS-1:0] irq_en_r;

   logic [RW-1:0]        region_s;
   logic [RW-1:0]        slot_idx_s;
   logic [NUM_SLOTS-1:0] slot_onehot_s;
   logic                 accept_s;
   logic                 resp_s;
   logic [31:0]          rdat_s;
   logic [31:0]          csr_rdat_s;
   logic [NUM_SLOTS-1:0] tout_set_s;
   logic [NUM_SLOTS-1:0] tout_clr_s;
   logic                 ack_hit_s;
   logic [31:0]          slot_rdat_s;
   logic                 csr_wr_s;
   logic [31:0]          wmask_s;
   logic [31:0]          sel_wr_s;
   logic [31:0]          irq_en_wr_s;
   logic [IO_PADS-1:0]   io_out_s;
   logic [IO_PADS-1:0]   io_oeb_s;
   logic [31:0]          la_out_s;
   logic [2:0]           irq_s;
   logic                 unused_s;

   assign region_s   = wbs_adr_i[SLOT_SPAN_LOG2 +: RW];
   assign slot_idx_s = region_s - RW'(1);

   // Pad/LA inputs fan out in the parent; upper address bits are don't-care.
   assign unused_s = ^{wbs_adr_i, io_in, la_data_in, la_oenb};

   // Slot decode one-hot, and ack/read-data select for the latched slot
   always_comb begin
      slot_onehot_s = '0;
      ack_hit_s     = 1'b0;
      slot_rdat_s   = 32'h0000_0000;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (slot_idx_s == RW'(i)) begin
            slot_onehot_s[i] = 1'b1;
         end else begin
            slot_onehot_s[i] = 1'b0;
         end
         if (slot_idx_r == RW'(i)) begin
            ack_hit_s   = slot_bus.slot_ack_i[i];
            slot_rdat_s = slot_bus.slot_dat_i[32*i +: 32];
         end else begin
            ack_hit_s   = ack_hit_s;
            slot_rdat_s = slot_rdat_s;
         end
      end
   end

   // CSR read data, taken from the live registers when the request is accepted
   always_comb begin
      csr_rdat_s = 32'h0000_0000;
      case (wbs_adr_i[3:2])
         CSR_SEL:    csr_rdat_s = {29'd0, sel_csr_r};
         CSR_TOUT:   csr_rdat_s = {{(32-NUM_SLOTS){1'b0}}, tout_r};
         CSR_IRQ_EN: csr_rdat_s = {{(32-NUM_SLOTS){1'b0}}, irq_en_r};
         CSR_RSVD:   csr_rdat_s = 32'h0000_0000;
         default:    csr_rdat_s = 32'h0000_0000;
      endcase
   end

   // FSM next state, response data and sticky-timeout set mask
   always_comb begin
      state_s    = state_r;
      accept_s   = 1'b0;
      resp_s     = 1'b0;
      rdat_s     = 32'h0000_0000;
      tout_set_s = '0;
      case (state_r)
         ST_IDLE: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               accept_s = 1'b1;
               if (region_s == RW'(0)) begin
                  state_s = ST_CSR_RESP;
                  resp_s  = 1'b1;
                  rdat_s  = csr_rdat_s;
               end else if (region_s <= RW'(NUM_SLOTS)) begin
                  state_s = ST_SLOT_WAIT;
               end else begin
                  // unmapped: answer with zero, touch nothing
                  state_s = ST_ERR_RESP;
                  resp_s  = 1'b1;
                  rdat_s  = 32'h0000_0000;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SLOT_WAIT: begin
            // abort beats ack; ack beats a coincident timeout
            if (!wbs_cyc_i) begin
               state_s = ST_IDLE;
            end else if (ack_hit_s) begin
               state_s = ST_RESP;
               resp_s  = 1'b1;
               rdat_s  = slot_rdat_s;
            end else if (cnt_r == CW'(TIMEOUT_CYCLES - 1)) begin
               state_s    = ST_ERR_RESP;
               resp_s     = 1'b1;
               rdat_s     = ERR_DATA;
               tout_set_s = slot_stb_r;
            end else begin
               state_s = ST_SLOT_WAIT;
            end
         end
         ST_CSR_RESP: state_s = ST_IDLE;
         ST_RESP:     state_s = ST_IDLE;
         ST_ERR_RESP: state_s = ST_IDLE;
         default:     state_s = ST_IDLE;
      endcase
   end

   // CSR write path: applied in the response cycle so pads switch after the ack
   always_comb begin
      csr_wr_s    = (state_r == ST_CSR_RESP) && we_r;
      wmask_s     = {{8{sel_r[3]}}, {8{sel_r[2]}}, {8{sel_r[1]}}, {8{sel_r[0]}}};
      sel_wr_s    = ({29'd0, sel_csr_r} & ~wmask_s) | (dat_r & wmask_s);
      irq_en_wr_s = ({{(32-NUM_SLOTS){1'b0}}, irq_en_r} & ~wmask_s) | (dat_r & wmask_s);
      if (csr_wr_s && (adr_r[3:2] == CSR_TOUT)) begin
         tout_clr_s = dat_r[NUM_SLOTS-1:0] & wmask_s[NUM_SLOTS-1:0];
      end else begin
         tout_clr_s = '0;
      end
   end

   // Transfer state: FSM register, latched request, slot strobes, timeout counter
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         state_r    <= ST_IDLE;
         cnt_r      <= '0;
         slot_idx_r <= '0;
         slot_stb_r <= '0;
         we_r       <= 1'b0;
         sel_r      <= 4'h0;
         adr_r      <= 32'h0000_0000;
         dat_r      <= 32'h0000_0000;
         ack_r      <= 1'b0;
         rdat_r     <= 32'h0000_0000;
      end else begin
         state_r <= state_s;
         ack_r   <= resp_s;
         if (resp_s) begin
            rdat_r <= rdat_s;
         end
         if (accept_s) begin
            we_r       <= wbs_we_i;
            sel_r      <= wbs_sel_i;
            adr_r      <= {{(32-SLOT_SPAN_LOG2){1'b0}}, wbs_adr_i[SLOT_SPAN_LOG2-1:0]};
            dat_r      <= wbs_dat_i;
            slot_idx_r <= slot_idx_s;
            cnt_r      <= '0;
            if (state_s == ST_SLOT_WAIT) begin
               slot_stb_r <= slot_onehot_s;
            end else begin
               slot_stb_r <= '0;
            end
         end else if (state_r == ST_SLOT_WAIT) begin
            if (state_s != ST_SLOT_WAIT) begin
               slot_stb_r <= '0;
            end else begin
               cnt_r <= cnt_r + CW'(1);
            end
         end
      end
   end

   // Control/status registers
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         sel_csr_r <= 3'd0;
         tout_r    <= '0;
         irq_en_r  <= '0;
      end else begin
         tout_r <= (tout_r & ~tout_clr_s) | tout_set_s;
         if (csr_wr_s && (adr_r[3:2] == CSR_SEL)) begin
            sel_csr_r <= sel_wr_s[2:0];
         end
         if (csr_wr_s && (adr_r[3:2] == CSR_IRQ_EN)) begin
            irq_en_r <= irq_en_wr_s[NUM_SLOTS-1:0];
         end
      end
   end

   assign slot_bus.slot_cyc_o = slot_stb_r;
   assign slot_bus.slot_stb_o = slot_stb_r;
   assign slot_bus.slot_we_o  = we_r;
   assign slot_bus.slot_sel_o = sel_r;
   assign slot_bus.slot_adr_o = adr_r;
   assign slot_bus.slot_dat_o = dat_r;

   // Pad/LA routing from the selected slot; out-of-range selects park the pads
   always_comb begin
      io_out_s = '0;
      io_oeb_s = '1;
      la_out_s = 32'h0000_0000;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (sel_csr_r == 3'(i)) begin
            io_out_s = slot_io_out_i[IO_PADS*i +: IO_PADS];
            io_oeb_s = slot_io_oeb_i[IO_PADS*i +: IO_PADS];
            la_out_s = slot_la_data_out_i[32*i +: 32];
         end else begin
            io_out_s = io_out_s;
            io_oeb_s = io_oeb_s;
            la_out_s = la_out_s;
         end
      end
   end

   // Interrupts: enabled slots OR-ed; any sticky timeout raises irq[2]
   always_comb begin
      irq_s = 3'b000;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (irq_en_r[i]) begin
            irq_s = irq_s | slot_irq_i[3*i +: 3];
         end else begin
            irq_s = irq_s;
         end
      end
      irq_s[2] = irq_s[2] | (|tout_r);
   end

   active_gate #(.WIDTH(1))       u_gate_ack  (.active(active), .in_bus(ack_r),    .out_bus(wbs_ack_o));
   active_gate #(.WIDTH(32))      u_gate_dat  (.active(active), .in_bus(rdat_r),   .out_bus(wbs_dat_o));
   active_gate #(.WIDTH(32))      u_gate_la   (.active(active), .in_bus(la_out_s), .out_bus(la_data_out));
   active_gate #(.WIDTH(IO_PADS)) u_gate_io   (.active(active), .in_bus(io_out_s), .out_bus(io_out));
   active_gate #(.WIDTH(IO_PADS)) u_gate_oeb  (.active(active), .in_bus(io_oeb_s), .out_bus(io_oeb));
   active_gate #(.WIDTH(3))       u_gate_irq  (.active(active), .in_bus(irq_s),    .out_bus(irq));

endmodule
